wb_mem_writeback_unit: RTL and testbench

//   Consumer of the EX/WB pipeline register: performs the data-memory access for LW/SW, the

---
 rtl/skylark_wb_pkg.sv | 21 ++
 rtl/wb_popcount_iter.sv | 59 +++++
 rtl/wb_mem_writeback_unit.sv | 150 +++++++++++++++
 tb/tb_wb_mem_writeback_unit.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/skylark_wb_pkg.sv
// rtl/skylark_wb_pkg.sv - shared types for the writeback stage
package skylark_wb_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        RES_ALU    = 2'b00,
        RES_LOAD   = 2'b01,
        RES_PC     = 2'b10,
        RES_POPCNT = 2'b11
    } result_src_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_MEM_REQ  = 3'd1,
        ST_MEM_WAIT = 3'd2,
        ST_POPCNT   = 3'd3,
        ST_DONE     = 3'd4
    } wb_state_t;

endpackage

// File: rtl/wb_popcount_iter.sv
// rtl/wb_popcount_iter.sv - chunked sequential popcount, CHUNK bits per cycle
module wb_popcount_iter
    import skylark_wb_pkg::*;
#(
    parameter int CHUNK = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] operand,
    output logic              busy,
    output logic              done,
    output logic [5:0]        count
);

    localparam int N = DATA_W / CHUNK;

    logic [DATA_W-1:0] r_operand;
    logic [5:0]        r_idx;
    logic [5:0]        r_acc;
    logic              r_busy;
    logic [CHUNK-1:0]  w_chunk;
    logic              w_last;

    function automatic logic [5:0] chunk_ones(input logic [CHUNK-1:0] b);
        logic [5:0] c;
        c = 6'd0;
        for (int i = 0; i < CHUNK; i++) c = c + 6'(b[i]);
        return c;
    endfunction

    // The operand is shifted down each cycle so the low chunk is always the one counted.
    assign w_chunk = r_operand[CHUNK-1:0];
    assign w_last  = r_busy && (r_idx == 6'(N - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_operand <= '0;
            r_idx     <= 6'd0;
            r_acc     <= 6'd0;
            r_busy    <= 1'b0;
        end else if (start) begin
            r_operand <= operand;
            r_idx     <= 6'd0;
            r_acc     <= 6'd0;
            r_busy    <= 1'b1;
        end else if (r_busy) begin
            r_acc     <= r_acc + chunk_ones(w_chunk);
            r_operand <= r_operand >> CHUNK;
            r_idx     <= r_idx + 6'd1;
            if (w_last) r_busy <= 1'b0;
        end
    end

    assign busy  = r_busy;
    assign done  = w_last;
    assign count = r_acc;

endmodule

// File: rtl/wb_mem_writeback_unit.sv
// rtl/wb_mem_writeback_unit.sv - EX/WB consumer: data-memory access, popcount, register-file write
module wb_mem_writeback_unit
    import skylark_wb_pkg::*;
#(
    parameter int POPCNT_CHUNK = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ValidW,
    input  logic              RegWriteW,
    input  logic [1:0]        ResultSrcW,
    input  logic              MemWriteW,
    input  logic [4:0]        A3_W,
    input  logic [DATA_W-1:0] RD2_W,
    input  logic [DATA_W-1:0] ALUResultW,
    input  logic [DATA_W-1:0] length_adjusted_W,
    input  logic [DATA_W-1:0] PCNextW,
    output logic              dmem_req_valid,
    input  logic              dmem_req_ready,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_rvalid,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              WE3,
    output logic [4:0]        A3,
    output logic [DATA_W-1:0] WD3,
    output logic              StallW
);

    wb_state_t         r_state;
    logic              r_store;
    logic              r_is_pop;
    logic              r_regwrite;
    logic [4:0]        r_a3;
    logic [DATA_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;

    logic              w_is_load;
    logic              w_is_pop;
    logic              w_accept;
    logic              w_start;
    logic              w_pc_busy;
    logic              w_pc_done;
    logic [5:0]        w_pc_count;

    // Stores take priority: any MemWriteW goes to memory regardless of ResultSrcW.
    assign w_is_load = (ResultSrcW == RES_LOAD) && !MemWriteW;
    assign w_is_pop  = (ResultSrcW == RES_POPCNT) && !MemWriteW;
    assign w_accept  = ValidW && (MemWriteW || w_is_load || w_is_pop);
    assign w_start   = (r_state == ST_IDLE) && w_accept && w_is_pop;

    wb_popcount_iter #(
        .CHUNK (POPCNT_CHUNK)
    ) u_popcount (
        .clk     (clk),
        .reset   (reset),
        .start   (w_start),
        .operand (length_adjusted_W),
        .busy    (w_pc_busy),
        .done    (w_pc_done),
        .count   (w_pc_count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_store    <= 1'b0;
            r_is_pop   <= 1'b0;
            r_regwrite <= 1'b0;
            r_a3       <= 5'd0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_store    <= MemWriteW;
                        r_is_pop   <= w_is_pop;
                        r_regwrite <= RegWriteW;
                        r_a3       <= A3_W;
                        r_addr     <= ALUResultW;
                        r_wdata    <= RD2_W;
                        r_rdata    <= '0;
                        r_state    <= w_is_pop ? ST_POPCNT : ST_MEM_REQ;
                    end
                end
                ST_MEM_REQ: begin
                    if (dmem_req_ready) r_state <= r_store ? ST_DONE : ST_MEM_WAIT;
                end
                ST_MEM_WAIT: begin
                    if (dmem_rvalid) begin
                        r_rdata <= dmem_rdata;
                        r_state <= ST_DONE;
                    end
                end
                ST_POPCNT: begin
                    if (w_pc_done || !w_pc_busy) r_state <= ST_DONE;
                end
                // EX/WB advances on this edge, so its stale contents must not be re-accepted.
                ST_DONE:  r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        dmem_req_valid = 1'b0;
        dmem_we        = 1'b0;
        dmem_addr      = '0;
        dmem_wdata     = '0;
        WE3            = 1'b0;
        A3             = 5'd0;
        WD3            = '0;
        StallW         = 1'b0;
        if (reset) begin
            case (r_state)
                ST_IDLE: begin
                    if (ValidW) begin
                        if (w_accept) begin
                            StallW = 1'b1;
                        end else begin
                            WE3 = RegWriteW && (A3_W != 5'd0);
                            A3  = A3_W;
                            WD3 = (ResultSrcW == RES_PC) ? PCNextW : ALUResultW;
                        end
                    end
                end
                ST_MEM_REQ: begin
                    dmem_req_valid = 1'b1;
                    dmem_we        = r_store;
                    dmem_addr      = r_addr;
                    dmem_wdata     = r_wdata;
                    StallW         = 1'b1;
                end
                ST_MEM_WAIT: StallW = 1'b1;
                ST_POPCNT:   StallW = 1'b1;
                ST_DONE: begin
                    WE3 = r_regwrite && (r_a3 != 5'd0) && !r_store;
                    A3  = r_a3;
                    WD3 = r_is_pop ? {26'b0, w_pc_count} : r_rdata;
                end
                default: StallW = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_mem_writeback_unit.sv
// tb/tb_wb_mem_writeback_unit.sv - directed self-checking bench for wb_mem_writeback_unit
module tb_wb_mem_writeback_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        ValidW, RegWriteW, MemWriteW;
    logic [1:0]  ResultSrcW;
    logic [4:0]  A3_W;
    logic [31:0] RD2_W, ALUResultW, length_adjusted_W, PCNextW;
    logic        dmem_req_valid, dmem_req_ready, dmem_we, dmem_rvalid;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        WE3, StallW;
    logic [4:0]  A3;
    logic [31:0] WD3;

    int checks = 0;
    int failures = 0;

    wb_mem_writeback_unit #(.POPCNT_CHUNK(8)) dut (
        .clk(clk), .reset(reset), .ValidW(ValidW), .RegWriteW(RegWriteW),
        .ResultSrcW(ResultSrcW), .MemWriteW(MemWriteW), .A3_W(A3_W), .RD2_W(RD2_W),
        .ALUResultW(ALUResultW), .length_adjusted_W(length_adjusted_W), .PCNextW(PCNextW),
        .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rvalid(dmem_rvalid),
        .dmem_rdata(dmem_rdata), .WE3(WE3), .A3(A3), .WD3(WD3), .StallW(StallW)
    );

    always #5 clk = ~clk;

    task automatic clear_inputs();
        ValidW = 0; RegWriteW = 0; MemWriteW = 0; ResultSrcW = 2'b00; A3_W = 0;
        RD2_W = 0; ALUResultW = 0; length_adjusted_W = 0; PCNextW = 0;
        dmem_req_ready = 0; dmem_rvalid = 0; dmem_rdata = 0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 0;
        ValidW = 1; RegWriteW = 1; ResultSrcW = 2'b00; A3_W = 5; ALUResultW = 32'h1234;
        @(negedge clk);
        checks++; if (WE3 !== 1'b0) begin failures++; $display("FAIL reset_we3 got=%0h exp=0", WE3); end
        checks++; if (StallW !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0h exp=0", StallW); end
        checks++; if (WD3 !== 32'h0) begin failures++; $display("FAIL reset_wd3 got=%0h exp=0", WD3); end
        checks++; if (dmem_req_valid !== 1'b0) begin failures++; $display("FAIL reset_req got=%0h exp=0", dmem_req_valid); end
        clear_inputs();
        step();
        reset = 1;
    endtask

    task automatic test_alu();
        ValidW = 1; RegWriteW = 1; ResultSrcW = 2'b00; A3_W = 5; ALUResultW = 32'h1234; PCNextW = 32'h88;
        @(negedge clk);
        checks++; if (WE3 !== 1'b1) begin failures++; $display("FAIL alu_we3 got=%0h exp=1", WE3); end
        checks++; if (A3 !== 5'd5) begin failures++; $display("FAIL alu_a3 got=%0d exp=5", A3); end
        checks++; if (WD3 !== 32'h1234) begin failures++; $display("FAIL alu_wd3 got=%0h exp=1234", WD3); end
        checks++; if (StallW !== 1'b0) begin failures++; $display("FAIL alu_stall got=%0h exp=0", StallW); end
        step();
        ResultSrcW = 2'b10; A3_W = 1; PCNextW = 32'h80;
        @(negedge clk);
        checks++; if (WD3 !== 32'h80) begin failures++; $display("FAIL jal_wd3 got=%0h exp=80", WD3); end
        checks++; if (WE3 !== 1'b1) begin failures++; $display("FAIL jal_we3 got=%0h exp=1", WE3); end
        step();
        ResultSrcW = 2'b00; A3_W = 0;
        @(negedge clk);
        checks++; if (WE3 !== 1'b0) begin failures++; $display("FAIL alu_x0_we3 got=%0h exp=0", WE3); end
        step();
        clear_inputs();
        @(negedge clk);
        checks++; if (WE3 !== 1'b0 || StallW !== 1'b0 || WD3 !== 32'h0) begin
            failures++; $display("FAIL idle_invalid we3=%0h stall=%0h wd3=%0h exp=0", WE3, StallW, WD3);
        end
        step();
    endtask

    task automatic test_popcount(input logic [31:0] operand, input logic [4:0] rd, input logic [31:0] exp_cnt);
        ValidW = 1; RegWriteW = 1; ResultSrcW = 2'b11; A3_W = rd; length_adjusted_W = operand;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (StallW !== 1'b1 || WE3 !== 1'b0) begin
                failures++; $display("FAIL pop_busy cycle=%0d stall=%0h we3=%0h exp stall=1 we3=0", i, StallW, WE3);
            end
            step();
        end
        @(negedge clk);
        checks++; if (StallW !== 1'b0) begin failures++; $display("FAIL pop_done_stall got=%0h exp=0", StallW); end
        checks++; if (WE3 !== 1'b1) begin failures++; $display("FAIL pop_we3 got=%0h exp=1", WE3); end
        checks++; if (WD3 !== exp_cnt) begin failures++; $display("FAIL pop_wd3 got=%0d exp=%0d", WD3, exp_cnt); end
        checks++; if (A3 !== rd) begin failures++; $display("FAIL pop_a3 got=%0d exp=%0d", A3, rd); end
        step();
        clear_inputs();
        @(negedge clk);
        checks++; if (StallW !== 1'b0 || WE3 !== 1'b0) begin
            failures++; $display("FAIL pop_after stall=%0h we3=%0h exp=0", StallW, WE3);
        end
        step();
    endtask

    task automatic test_store();
        logic we_seen;
        we_seen = 0;
        ValidW = 1; RegWriteW = 1; MemWriteW = 1; A3_W = 9; ALUResultW = 32'h100; RD2_W = 32'hDEAD;
        @(negedge clk);
        we_seen |= WE3;
        checks++; if (StallW !== 1'b1 || dmem_req_valid !== 1'b0) begin
            failures++; $display("FAIL st_accept stall=%0h req=%0h exp stall=1 req=0", StallW, dmem_req_valid);
        end
        step();
        for (int i = 0; i < 4; i++) begin
            dmem_req_ready = (i == 3);
            @(negedge clk);
            we_seen |= WE3;
            checks++; if (dmem_req_valid !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== 32'h100 ||
                          dmem_wdata !== 32'hDEAD || StallW !== 1'b1) begin
                failures++;
                $display("FAIL st_req cycle=%0d valid=%0h we=%0h addr=%0h wdata=%0h stall=%0h exp 1 1 100 dead 1",
                         i, dmem_req_valid, dmem_we, dmem_addr, dmem_wdata, StallW);
            end
            step();
        end
        dmem_req_ready = 0;
        @(negedge clk);
        we_seen |= WE3;
        checks++; if (StallW !== 1'b0 || dmem_req_valid !== 1'b0) begin
            failures++; $display("FAIL st_done stall=%0h req=%0h exp=0", StallW, dmem_req_valid);
        end
        step();
        clear_inputs();
        @(negedge clk);
        we_seen |= WE3;
        checks++; if (we_seen !== 1'b0) begin failures++; $display("FAIL st_we3_seen got=%0h exp=0", we_seen); end
        step();
    endtask

    task automatic test_load();
        ValidW = 1; RegWriteW = 1; ResultSrcW = 2'b01; A3_W = 4; ALUResultW = 32'h40;
        step();
        dmem_req_ready = 1; dmem_rvalid = 1; dmem_rdata = 32'hBAD;
        @(negedge clk);
        checks++; if (dmem_req_valid !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== 32'h40) begin
            failures++; $display("FAIL ld_req valid=%0h we=%0h addr=%0h exp 1 0 40", dmem_req_valid, dmem_we, dmem_addr);
        end
        step();
        dmem_req_ready = 0; dmem_rvalid = 0; dmem_rdata = 0;
        @(negedge clk);
        checks++; if (StallW !== 1'b1 || WE3 !== 1'b0 || dmem_req_valid !== 1'b0) begin
            failures++; $display("FAIL ld_wait stall=%0h we3=%0h req=%0h exp 1 0 0", StallW, WE3, dmem_req_valid);
        end
        step();
        dmem_rvalid = 1; dmem_rdata = 32'hCAFE;
        @(negedge clk);
        checks++; if (StallW !== 1'b1) begin failures++; $display("FAIL ld_wait2_stall got=%0h exp=1", StallW); end
        step();
        dmem_rvalid = 0; dmem_rdata = 0;
        @(negedge clk);
        checks++; if (WE3 !== 1'b1 || WD3 !== 32'hCAFE || A3 !== 5'd4 || StallW !== 1'b0) begin
            failures++; $display("FAIL ld_done we3=%0h wd3=%0h a3=%0d stall=%0h exp 1 cafe 4 0", WE3, WD3, A3, StallW);
        end
        step();
        clear_inputs();
        @(negedge clk);
        checks++; if (WE3 !== 1'b0) begin failures++; $display("FAIL ld_pulse got=%0h exp=0", WE3); end
        step();
    endtask

    task automatic test_load_x0();
        ValidW = 1; RegWriteW = 1; ResultSrcW = 2'b01; A3_W = 0; ALUResultW = 32'h44;
        step();
        dmem_req_ready = 1;
        @(negedge clk);
        checks++; if (dmem_req_valid !== 1'b1 || dmem_addr !== 32'h44) begin
            failures++; $display("FAIL x0_req valid=%0h addr=%0h exp 1 44", dmem_req_valid, dmem_addr);
        end
        step();
        dmem_req_ready = 0; dmem_rvalid = 1; dmem_rdata = 32'h77;
        step();
        dmem_rvalid = 0;
        @(negedge clk);
        checks++; if (WE3 !== 1'b0 || StallW !== 1'b0) begin
            failures++; $display("FAIL x0_done we3=%0h stall=%0h exp=0", WE3, StallW);
        end
        step();
        clear_inputs();
        @(negedge clk);
        checks++; if (dmem_req_valid !== 1'b0 || StallW !== 1'b0) begin
            failures++; $display("FAIL x0_reissue req=%0h stall=%0h exp=0", dmem_req_valid, StallW);
        end
        step();
    endtask

    task automatic test_reset_mid();
        ValidW = 1; RegWriteW = 1; ResultSrcW = 2'b01; A3_W = 6; ALUResultW = 32'h60;
        step();
        dmem_req_ready = 1;
        step();
        dmem_req_ready = 0;
        @(negedge clk);
        checks++; if (StallW !== 1'b1) begin failures++; $display("FAIL rm_wait_stall got=%0h exp=1", StallW); end
        #1 reset = 0;
        #1;
        checks++; if (dmem_req_valid !== 1'b0 || WE3 !== 1'b0 || StallW !== 1'b0) begin
            failures++; $display("FAIL rm_async req=%0h we3=%0h stall=%0h exp=0", dmem_req_valid, WE3, StallW);
        end
        step();
        clear_inputs();
        reset = 1;
        dmem_rvalid = 1; dmem_rdata = 32'h5555;
        @(negedge clk);
        checks++; if (WE3 !== 1'b0 || StallW !== 1'b0) begin
            failures++; $display("FAIL rm_late_rvalid we3=%0h stall=%0h exp=0", WE3, StallW);
        end
        step();
        dmem_rvalid = 0;
        @(negedge clk);
        checks++; if (WE3 !== 1'b0 || dmem_req_valid !== 1'b0) begin
            failures++; $display("FAIL rm_after we3=%0h req=%0h exp=0", WE3, dmem_req_valid);
        end
        step();
    endtask

    initial begin
        clear_inputs();
        reset = 0;
        #1;
        test_reset();
        test_alu();
        test_popcount(32'hF0F0_00FF, 5'd7, 32'd16);
        test_popcount(32'hFFFF_FFFF, 5'd3, 32'd32);
        test_store();
        test_load();
        test_load_x0();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
